// File: rtl/id_pipe_pkg.sv
// Shared decode definitions for ID and EX: opcode constants, memory access length
// encoding, immediate formats and small decode helpers.
package id_pipe_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_len_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_OP, OPC_OP32:     fmt = IMM_NONE;
      OPC_STORE:            fmt = IMM_S;
      OPC_BRANCH:           fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:   fmt = IMM_U;
      OPC_JAL:              fmt = IMM_J;
      default:              fmt = IMM_I;
    endcase
    return fmt;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPC_OP || opcode == OPC_OP32 ||
            opcode == OPC_STORE || opcode == OPC_BRANCH);
  endfunction

  // Immediate sign-extended to 32 bits; the caller widens to XLEN.
  function automatic logic [31:0] imm32(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_pipe_fwd_sel.sv
// Operand selector for one source register: x0, youngest matching forwarding slot,
// or regfile data, plus a load-use hazard flag for the selected slot.
module id_fwd_sel #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]              rs_addr,
  input  logic                    rs_used,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_load,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic [XLEN-1:0]         data,
  output logic                    hazard
);

  logic sel_load;

  // Walk oldest to youngest so the lowest-index match has the final say.
  always_comb begin
    data     = rf_data;
    sel_load = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[5*i +: 5] == rs_addr)) begin
        data     = fwd_data[XLEN*i +: XLEN];
        sel_load = fwd_load[i];
      end
    end
    if (rs_addr == 5'd0) begin
      data     = '0;
      sel_load = 1'b0;
    end
    hazard = rs_used & sel_load;
  end

endmodule

// File: rtl/id_pipe.sv
// Registered RV64 decode stage with operand forwarding, load-use interlock,
// immediate generation and a pre-checked dcache request.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int NUM_FWD     = 3,
  parameter int STALL_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             inst_i,
  input  logic [XLEN-1:0]         pc_i,
  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  input  logic [XLEN-1:0]         rs1_data_i,
  input  logic [XLEN-1:0]         rs2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [NUM_FWD-1:0]      fwd_load_i,
  input  logic [5*NUM_FWD-1:0]    fwd_rd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [6:0]              opcode_o,
  output logic [2:0]              funct3_o,
  output logic [6:0]              funct7_o,
  output logic [4:0]              rd_o,
  output logic                    wreg_o,
  output logic [XLEN-1:0]         rs1_data_o,
  output logic [XLEN-1:0]         rs2_data_o,
  output logic [XLEN-1:0]         imm_o,
  output logic [XLEN-1:0]         pc_o,
  output logic                    mem_req_o,
  output logic                    mem_wen_o,
  output logic [XLEN-1:0]         mem_addr_o,
  output logic [XLEN-1:0]         mem_wdata_o,
  output logic [1:0]              mem_len_o,
  output logic                    misalign_o,
  output logic [STALL_CNT_W-1:0]  stall_cnt_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  imm_fmt_e        imm_fmt;
  logic [31:0]     imm_short;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rs1_sel;
  logic [XLEN-1:0] rs2_sel;
  logic            rs1_hazard;
  logic            rs2_hazard;
  logic            hazard;
  logic            transfer;
  logic            is_load;
  logic            is_store;
  logic            mem_op;
  mem_len_e        mem_len;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] store_data;
  logic            misalign;
  logic            wreg;

  assign opcode     = inst_i[6:0];
  assign funct3     = inst_i[14:12];
  assign rd         = inst_i[11:7];
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  assign imm_fmt   = imm_format(opcode);
  assign imm_short = imm32(inst_i, imm_fmt);
  assign imm_ext   = {{(XLEN-32){imm_short[31]}}, imm_short};

  id_fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_rs1_sel (
    .rs_addr   (rs1_addr_o),
    .rs_used   (uses_rs1(opcode)),
    .rf_data   (rs1_data_i),
    .fwd_valid (fwd_valid_i),
    .fwd_load  (fwd_load_i),
    .fwd_rd    (fwd_rd_i),
    .fwd_data  (fwd_data_i),
    .data      (rs1_sel),
    .hazard    (rs1_hazard)
  );

  id_fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_rs2_sel (
    .rs_addr   (rs2_addr_o),
    .rs_used   (uses_rs2(opcode)),
    .rf_data   (rs2_data_i),
    .fwd_valid (fwd_valid_i),
    .fwd_load  (fwd_load_i),
    .fwd_rd    (fwd_rd_i),
    .fwd_data  (fwd_data_i),
    .data      (rs2_sel),
    .hazard    (rs2_hazard)
  );

  assign hazard     = rs1_hazard | rs2_hazard;
  assign in_ready_o = !hazard && !flush_i && (!out_valid_o || out_ready_i);
  assign transfer   = in_valid_i && in_ready_o;

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign mem_op   = is_load || is_store;
  assign mem_len  = mem_len_e'(funct3[1:0]);
  assign mem_addr = rs1_sel + imm_ext;
  assign wreg     = !(opcode == OPC_BRANCH || is_store) && (rd != 5'd0);

  // Misaligned accesses never reach the dcache; EX sees misalign_o instead.
  always_comb begin
    misalign   = 1'b0;
    store_data = '0;
    case (mem_len)
      MEM_B: store_data = {{(XLEN-8){1'b0}}, rs2_sel[7:0]};
      MEM_H: begin
        store_data = {{(XLEN-16){1'b0}}, rs2_sel[15:0]};
        misalign   = mem_addr[0];
      end
      MEM_W: begin
        store_data = {{(XLEN-32){1'b0}}, rs2_sel[31:0]};
        misalign   = |mem_addr[1:0];
      end
      default: begin
        store_data = rs2_sel;
        misalign   = |mem_addr[2:0];
      end
    endcase
    misalign = misalign && mem_op;
  end

  // Output register: flush beats transfer, transfer beats a plain pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      opcode_o    <= '0;
      funct3_o    <= '0;
      funct7_o    <= '0;
      rd_o        <= '0;
      wreg_o      <= 1'b0;
      rs1_data_o  <= '0;
      rs2_data_o  <= '0;
      imm_o       <= '0;
      pc_o        <= '0;
      mem_req_o   <= 1'b0;
      mem_wen_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_len_o   <= '0;
      misalign_o  <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (transfer) begin
      out_valid_o <= 1'b1;
      opcode_o    <= opcode;
      funct3_o    <= funct3;
      funct7_o    <= inst_i[31:25];
      rd_o        <= rd;
      wreg_o      <= wreg;
      rs1_data_o  <= rs1_sel;
      rs2_data_o  <= rs2_sel;
      imm_o       <= imm_ext;
      pc_o        <= pc_i;
      mem_req_o   <= mem_op && !misalign;
      mem_wen_o   <= is_store && !misalign;
      mem_addr_o  <= mem_op ? mem_addr : '0;
      mem_wdata_o <= is_store ? store_data : '0;
      mem_len_o   <= mem_op ? mem_len : 2'd0;
      misalign_o  <= misalign;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (in_valid_i && hazard && !flush_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Directed self-checking bench for id_pipe with hand-computed expected values.
module tb_id_pipe;

  localparam int XLEN    = 64;
  localparam int NUM_FWD = 3;
  localparam int SCW     = 32;

  logic                    clk;
  logic                    rst_n;
  logic                    flush_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [31:0]             inst_i;
  logic [XLEN-1:0]         pc_i;
  logic [4:0]              rs1_addr_o;
  logic [4:0]              rs2_addr_o;
  logic [XLEN-1:0]         rs1_data_i;
  logic [XLEN-1:0]         rs2_data_i;
  logic [NUM_FWD-1:0]      fwd_valid_i;
  logic [NUM_FWD-1:0]      fwd_load_i;
  logic [5*NUM_FWD-1:0]    fwd_rd_i;
  logic [XLEN*NUM_FWD-1:0] fwd_data_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [6:0]              opcode_o;
  logic [2:0]              funct3_o;
  logic [6:0]              funct7_o;
  logic [4:0]              rd_o;
  logic                    wreg_o;
  logic [XLEN-1:0]         rs1_data_o;
  logic [XLEN-1:0]         rs2_data_o;
  logic [XLEN-1:0]         imm_o;
  logic [XLEN-1:0]         pc_o;
  logic                    mem_req_o;
  logic                    mem_wen_o;
  logic [XLEN-1:0]         mem_addr_o;
  logic [XLEN-1:0]         mem_wdata_o;
  logic [1:0]              mem_len_o;
  logic                    misalign_o;
  logic [SCW-1:0]          stall_cnt_o;

  int checkCount;
  int failCount;

  localparam logic [31:0] I_ADDI_M1  = 32'hFFF00293;
  localparam logic [31:0] I_ADD      = 32'h002081B3;
  localparam logic [31:0] I_LUI_POS  = 32'h000080B7;
  localparam logic [31:0] I_LUI_NEG  = 32'h800080B7;
  localparam logic [31:0] I_SW_OFF2  = 32'h0020A123;
  localparam logic [31:0] I_SW_OFF4  = 32'h0020A223;
  localparam logic [31:0] I_BEQ_M4   = 32'hFE208EE3;

  id_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .STALL_CNT_W(SCW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_i      (inst_i),
    .pc_i        (pc_i),
    .rs1_addr_o  (rs1_addr_o),
    .rs2_addr_o  (rs2_addr_o),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .fwd_valid_i (fwd_valid_i),
    .fwd_load_i  (fwd_load_i),
    .fwd_rd_i    (fwd_rd_i),
    .fwd_data_i  (fwd_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .opcode_o    (opcode_o),
    .funct3_o    (funct3_o),
    .funct7_o    (funct7_o),
    .rd_o        (rd_o),
    .wreg_o      (wreg_o),
    .rs1_data_o  (rs1_data_o),
    .rs2_data_o  (rs2_data_o),
    .imm_o       (imm_o),
    .pc_o        (pc_o),
    .mem_req_o   (mem_req_o),
    .mem_wen_o   (mem_wen_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_len_o   (mem_len_o),
    .misalign_o  (misalign_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] inst, input logic [63:0] pc,
                               input logic [63:0] rf1, input logic [63:0] rf2);
    in_valid_i = valid;
    inst_i     = inst;
    pc_i       = pc;
    rs1_data_i = rf1;
    rs2_data_i = rf2;
  endtask

  task automatic setSlot(input int idx, input logic valid, input logic load,
                         input logic [4:0] rd, input logic [63:0] data);
    fwd_valid_i[idx]           = valid;
    fwd_load_i[idx]            = load;
    fwd_rd_i[5*idx +: 5]       = rd;
    fwd_data_i[XLEN*idx +: XLEN] = data;
  endtask

  task automatic clearSlots();
    fwd_valid_i = '0;
    fwd_load_i  = '0;
    fwd_rd_i    = '0;
    fwd_data_i  = '0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount  = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    clearSlots();

    repeat (2) stepCycle();
    checkOutput("reset_out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("reset_imm", imm_o, 64'd0);
    checkOutput("reset_pc", pc_o, 64'd0);
    checkOutput("reset_stall_cnt", 64'(stall_cnt_o), 64'd0);
    rst_n = 1'b1;
    stepCycle();

    // addi x5,x0,-1 with a pending load to x0 in slot0: x0 never forwards or stalls
    setSlot(0, 1'b1, 1'b1, 5'd0, 64'h99);
    applyStimulus(1'b1, I_ADDI_M1, 64'h8000_0000, 64'h1234, 64'h0);
    #1;
    checkOutput("addi_in_ready", 64'(in_ready_o), 64'd1);
    checkOutput("addi_rs1_addr", 64'(rs1_addr_o), 64'd0);
    stepCycle();
    in_valid_i = 1'b0;
    checkOutput("addi_out_valid", 64'(out_valid_o), 64'd1);
    checkOutput("addi_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_rd", 64'(rd_o), 64'd5);
    checkOutput("addi_wreg", 64'(wreg_o), 64'd1);
    checkOutput("addi_mem_req", 64'(mem_req_o), 64'd0);
    checkOutput("addi_rs1_data", rs1_data_o, 64'd0);
    checkOutput("addi_pc", pc_o, 64'h8000_0000);
    checkOutput("addi_opcode", 64'(opcode_o), 64'h13);
    stepCycle();
    checkOutput("pop_out_valid", 64'(out_valid_o), 64'd0);

    // add x3,x1,x2: youngest slot wins, older load match behind it is ignored
    clearSlots();
    setSlot(0, 1'b1, 1'b0, 5'd1, 64'h11);
    setSlot(2, 1'b1, 1'b1, 5'd1, 64'h22);
    applyStimulus(1'b1, I_ADD, 64'h8000_0004, 64'h33, 64'h44);
    #1;
    checkOutput("fwd_in_ready", 64'(in_ready_o), 64'd1);
    stepCycle();
    in_valid_i = 1'b0;
    checkOutput("fwd_rs1_data", rs1_data_o, 64'h11);
    checkOutput("fwd_rs2_data", rs2_data_o, 64'h44);
    checkOutput("fwd_rd", 64'(rd_o), 64'd3);

    // load-use stall on x1 for two cycles, then the load data arrives
    clearSlots();
    setSlot(0, 1'b1, 1'b1, 5'd1, 64'h0);
    applyStimulus(1'b1, I_ADD, 64'h8000_0008, 64'h33, 64'h44);
    #1;
    checkOutput("stall_in_ready_0", 64'(in_ready_o), 64'd0);
    stepCycle();
    checkOutput("stall_in_ready_1", 64'(in_ready_o), 64'd0);
    checkOutput("stall_out_valid", 64'(out_valid_o), 64'd0);
    stepCycle();
    checkOutput("stall_cnt_2", 64'(stall_cnt_o), 64'd2);
    setSlot(0, 1'b1, 1'b0, 5'd1, 64'h55);
    #1;
    checkOutput("stall_release_ready", 64'(in_ready_o), 64'd1);
    stepCycle();
    checkOutput("stall_release_valid", 64'(out_valid_o), 64'd1);
    checkOutput("stall_release_rs1", rs1_data_o, 64'h55);
    checkOutput("stall_release_pc", pc_o, 64'h8000_0008);
    checkOutput("stall_cnt_hold", 64'(stall_cnt_o), 64'd2);

    // lui x1 ignores its rs1 field, so a load to x1 must not stall; back-to-back
    setSlot(0, 1'b1, 1'b1, 5'd1, 64'h0);
    applyStimulus(1'b1, I_LUI_POS, 64'h8000_000C, 64'h0, 64'h0);
    #1;
    checkOutput("lui_in_ready", 64'(in_ready_o), 64'd1);
    stepCycle();
    checkOutput("lui_imm_pos", imm_o, 64'h0000_0000_0000_8000);
    checkOutput("lui_rd", 64'(rd_o), 64'd1);
    inst_i = I_LUI_NEG;
    stepCycle();
    in_valid_i = 1'b0;
    checkOutput("lui_b2b_valid", 64'(out_valid_o), 64'd1);
    checkOutput("lui_imm_neg", imm_o, 64'hFFFF_FFFF_8000_8000);
    checkOutput("lui_stall_cnt", 64'(stall_cnt_o), 64'd2);

    // sw x2,2(x1) misaligned, then sw x2,4(x1) aligned
    clearSlots();
    applyStimulus(1'b1, I_SW_OFF2, 64'h8000_0010, 64'h1000, 64'hDEAD_BEEF_CAFE_F00D);
    stepCycle();
    checkOutput("sw2_misalign", 64'(misalign_o), 64'd1);
    checkOutput("sw2_mem_req", 64'(mem_req_o), 64'd0);
    checkOutput("sw2_wreg", 64'(wreg_o), 64'd0);
    inst_i = I_SW_OFF4;
    stepCycle();
    in_valid_i = 1'b0;
    checkOutput("sw4_misalign", 64'(misalign_o), 64'd0);
    checkOutput("sw4_mem_req", 64'(mem_req_o), 64'd1);
    checkOutput("sw4_mem_wen", 64'(mem_wen_o), 64'd1);
    checkOutput("sw4_mem_addr", mem_addr_o, 64'h1004);
    checkOutput("sw4_mem_len", 64'(mem_len_o), 64'd2);
    checkOutput("sw4_mem_wdata", mem_wdata_o, 64'h0000_0000_CAFE_F00D);

    // beq x1,x2,-4: negative B immediate, no register write
    applyStimulus(1'b1, I_BEQ_M4, 64'h8000_0018, 64'h0, 64'h0);
    stepCycle();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    checkOutput("beq_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("beq_wreg", 64'(wreg_o), 64'd0);

    // backpressure holds the register, then a flush empties it
    stepCycle();
    checkOutput("hold_valid", 64'(out_valid_o), 64'd1);
    checkOutput("hold_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, I_ADDI_M1, 64'h8000_001C, 64'h0, 64'h0);
    #1;
    checkOutput("bp_in_ready", 64'(in_ready_o), 64'd0);
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    #1;
    checkOutput("flush_in_ready", 64'(in_ready_o), 64'd0);
    stepCycle();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    checkOutput("flush_out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("flush_pc_kept", pc_o, 64'h8000_0018);

    // asynchronous reset in the middle of a cycle
    applyStimulus(1'b1, I_ADDI_M1, 64'h8000_0020, 64'h0, 64'h0);
    stepCycle();
    in_valid_i = 1'b0;
    checkOutput("pre_reset_valid", 64'(out_valid_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 64'(out_valid_o), 64'd0);
    checkOutput("async_reset_imm", imm_o, 64'd0);
    checkOutput("async_reset_rd", 64'(rd_o), 64'd0);
    checkOutput("async_reset_stall", 64'(stall_cnt_o), 64'd0);
    stepCycle();
    rst_n = 1'b1;
    stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
